m_muldiv_core: RTL and testbench

M_MULDIV_CORE -- requirements
Module: m_muldiv_core

---
 rtl/m_muldiv_core.sv | 244 ++++++++++++++++++++++++
 tb/tb_m_muldiv_core.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/m_muldiv_core.sv
// m_muldiv_core: RISC-V M-extension multiply/divide unit.
//   Multiplies go through a registered (XLEN+1)x(XLEN+1) signed multiplier
//   with MUL_LAT cycles of latency. Divides use a restoring radix-2 divider
//   on magnitudes, followed by a one-cycle sign fix-up.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   in_valid/in_ready           request handshake (ready only when idle)
//   op[2:0], rs1, rs2           funct3 and source operands
//   flush                       synchronous abort of the current operation
//   out_valid/out_ready, result result handshake (result reads 0 when not valid)
//   busy                        core is not idle
module m_muldiv_core #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned OW = XLEN + 1;
  localparam int unsigned PW = 2 * XLEN + 2;
  localparam int unsigned TW = 2 * XLEN;
  localparam int unsigned DW = 2 * XLEN - 1;
  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [OW-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d;
  logic [DW-1:0]   dvs_q, dvs_d;
  logic            negq_q, negq_d, negr_q, negr_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;

  // Request decode on the raw inputs (used only on the accept edge)
  logic            accept_c;
  logic            div_signed_in, neg_a_in, neg_b_in, div_zero_in, ovf_in;
  logic [OW-1:0]   a_ext_in, b_ext_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in, special_res;

  always_comb begin
    accept_c      = in_valid && in_ready_q && !flush;
    div_signed_in = !op[0];
    neg_a_in      = div_signed_in && rs1[XLEN-1];
    neg_b_in      = div_signed_in && rs2[XLEN-1];
    mag_a_in      = neg_a_in ? -rs1 : rs1;
    mag_b_in      = neg_b_in ? -rs2 : rs2;
    div_zero_in   = (rs2 == '0);
    ovf_in        = div_signed_in && (rs1 == MOST_NEG) && (rs2 == '1);
    // MULH extends both operands signed, MULHSU only rs1
    a_ext_in      = (op == 3'b001 || op == 3'b010) ? {rs1[XLEN-1], rs1} : {1'b0, rs1};
    b_ext_in      = (op == 3'b001) ? {rs2[XLEN-1], rs2} : {1'b0, rs2};
    if (div_zero_in) special_res = op[1] ? rs1 : '1;
    else             special_res = op[1] ? '0 : rs1;
  end

  // Multiplier: operands come straight from the inputs only when MUL_LAT is 1
  logic [OW-1:0]        mul_a, mul_b;
  logic [2:0]           op_sel;
  logic signed [PW-1:0] pa, pb;
  logic [TW-1:0]        prod;
  logic [XLEN-1:0]      mul_res;

  always_comb begin
    mul_a   = (state_q == S_IDLE) ? a_ext_in : a_q;
    mul_b   = (state_q == S_IDLE) ? b_ext_in : b_q;
    op_sel  = (state_q == S_IDLE) ? op : op_q;
    pa      = PW'($signed(mul_a));
    pb      = PW'($signed(mul_b));
    prod    = TW'(pa * pb);
    mul_res = (op_sel[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[TW-1:XLEN];
  end

  // One restoring step; the first step is taken on the accept edge itself
  logic [XLEN-1:0] rem_src, quo_src, rem_step, quo_step;
  logic [DW-1:0]   dvs_src, dvs_step;
  logic            take;

  always_comb begin
    rem_src  = (state_q == S_IDLE) ? mag_a_in : rem_q;
    dvs_src  = (state_q == S_IDLE) ? (DW'(mag_b_in) << (XLEN - 1)) : dvs_q;
    quo_src  = (state_q == S_IDLE) ? '0 : quo_q;
    // quotient bit is set when the trial subtraction stays non-negative
    take     = (TW'(rem_src) >= TW'(dvs_src));
    rem_step = take ? (rem_src - dvs_src[XLEN-1:0]) : rem_src;
    dvs_step = dvs_src >> 1;
    quo_step = XLEN'({quo_src, take});
  end

  // Sign fix-up of the magnitude results
  logic [XLEN-1:0] fix_res;

  always_comb begin
    if (op_q[1]) fix_res = negr_q ? -rem_q : rem_q;
    else         fix_res = negq_q ? -quo_q : quo_q;
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          op_d   = op;
          a_d    = a_ext_in;
          b_d    = b_ext_in;
          cnt_d  = '0;
          negq_d = neg_a_in ^ neg_b_in;
          negr_d = neg_a_in;
          if (!op[2]) begin
            if (MUL_LAT <= 1) begin
              state_d  = S_DONE;
              result_d = mul_res;
            end else begin
              state_d = S_MUL;
            end
          end else if (div_zero_in || ovf_in) begin
            state_d  = S_DONE;
            result_d = special_res;
          end else begin
            rem_d   = rem_step;
            dvs_d   = dvs_step;
            quo_d   = quo_step;
            cnt_d   = CW'(1);
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (cnt_q == CW'(MUL_LAT - 2)) begin
          state_d  = S_DONE;
          result_d = mul_res;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DIV: begin
        rem_d = rem_step;
        dvs_d = dvs_step;
        quo_d = quo_step;
        if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
        else                        cnt_d   = cnt_q + CW'(1);
      end
      S_FIX: begin
        state_d  = S_DONE;
        result_d = fix_res;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d  = S_IDLE;
          result_d = '0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        result_d = '0;
      end
    endcase

    // flush beats any accept or handshake in the same cycle
    if (flush) begin
      state_d  = S_IDLE;
      result_d = '0;
    end

    out_valid_d = (state_d == S_DONE);
    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_m_muldiv_core.sv
// Directed bench for m_muldiv_core (XLEN=32, MUL_LAT=2). Latency is counted
// in cycles after the accept edge: 1 means out_valid is already high in the
// cycle that follows the accept edge.
module tb_m_muldiv_core;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  m_muldiv_core #(.XLEN(32), .MUL_LAT(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op with out_ready high; check latency, result and handshake.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
    int lat;
    in_valid = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; rs1 = $urandom; rs2 = $urandom; op = 3'($urandom_range(0, 7));
    check({tag, " busy"}, 32'(busy), 32'd1);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " lat"}, 32'(lat), 32'(exp_lat));
    check({tag, " res"}, result, exp_r);
    check({tag, " rdy_busy"}, 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check({tag, " ov_drop"}, 32'(out_valid), 32'd0);
    check({tag, " res_zero"}, result, 32'd0);
    check({tag, " rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    resetn = 1'b0; in_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    flush = 1'b0; out_ready = 1'b1;

    #12;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst result", result, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("post rst in_ready", 32'(in_ready), 32'd1);

    run_op("MULH min*min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    run_op("MUL min*min",    3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 2);
    run_op("MUL 1234*5678",  3'b000, 32'd1234,      32'd5678,      32'd7006652,   2);
    run_op("MULHSU -1*max",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    run_op("MULHU max*max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_op("DIV -7/2",       3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    run_op("REM -7/2",       3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    run_op("DIV 7/-2",       3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("REM 7/-2",       3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33);
    run_op("DIVU 100/7",     3'b101, 32'd100,       32'd7,         32'd14,        33);
    run_op("REMU 100/7",     3'b111, 32'd100,       32'd7,         32'd2,         33);
    run_op("DIVU big/3",     3'b101, 32'hFFFF_FFFF, 32'd3,         32'h5555_5555, 33);
    run_op("DIVU x/0",       3'b101, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1);
    run_op("REMU x/0",       3'b111, 32'h0000_1234, 32'd0,         32'h0000_1234, 1);
    run_op("DIV -5/0",       3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1);
    run_op("DIV ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("DIVU min/-1",    3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33);

    // Back-pressure: hold out_ready low for 5 cycles in DONE
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp lat", 32'(lat), 32'd33);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp result", result, 32'd14);
      check("bp in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release ov", 32'(out_valid), 32'd0);
    check("bp release rdy", 32'(in_ready), 32'd1);

    // flush on the same edge as a request in IDLE: request is dropped
    in_valid = 1'b1; flush = 1'b1; op = 3'b000; rs1 = 32'd3; rs2 = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush+req busy", 32'(busy), 32'd0);
    check("flush+req rdy", 32'(in_ready), 32'd1);

    // flush at cycle 10 of a DIV
    in_valid = 1'b1; op = 3'b100; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush in_ready", 32'(in_ready), 32'd1);
    check("flush out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush no result", 32'(seen), 32'd0);

    // async reset in the middle of a MUL
    in_valid = 1'b1; op = 3'b000; rs1 = 32'd3; rs2 = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid mul busy", 32'(busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("rst mid ov", 32'(out_valid), 32'd0);
    check("rst mid rdy", 32'(in_ready), 32'd1);
    check("rst mid busy", 32'(busy), 32'd0);
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    check("rst rel rdy", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rst no result", 32'(seen), 32'd0);

    run_op("MUL after rst", 3'b000, 32'd3, 32'd5, 32'd15, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
